// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state enum, opcode/funct
// constants, ALU operation classes and the alucontrol field layout.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_ILLEGAL = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_SLT   = 2'd2,
    ALUOP_FUNCT = 2'd3
  } aluop_e;

  // alucontrol = {negate_b[5], unsigned[4], unit[3:2], op_hi[1], op_lo[0]}
  localparam logic [1:0] AC_UNIT_ARITH = 2'b00;
  localparam logic [1:0] AC_UNIT_LOGIC = 2'b01;
  localparam logic [1:0] AC_UNIT_SHIFT = 2'b10;
  localparam logic [1:0] AC_UNIT_SLT   = 2'b11;

  function automatic logic [5:0] ac_pack(input logic negb, input logic uns,
                                         input logic [1:0] unit,
                                         input logic op_hi, input logic op_lo);
    return {negb, uns, unit, op_hi, op_lo};
  endfunction

  function automatic logic funct_is_alu(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
                      FN_NOR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA,
                      FN_SLLV, FN_SRLV, FN_SRAV};
  endfunction

  function automatic logic funct_is_shamt(input logic [5:0] fn);
    return fn inside {FN_SLL, FN_SRL, FN_SRA};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: operation class plus funct field to the
// alucontrol fields expected by the ALU.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [5:0] alucontrol
);

  always_comb begin
    alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_ARITH, 1'b0, 1'b0);
    case (aluop)
      ALUOP_SUB: alucontrol = ac_pack(1'b1, 1'b0, AC_UNIT_ARITH, 1'b0, 1'b0);
      ALUOP_SLT: alucontrol = ac_pack(1'b1, 1'b0, AC_UNIT_SLT, 1'b0, 1'b0);
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADDU: alucontrol = ac_pack(1'b0, 1'b1, AC_UNIT_ARITH, 1'b0, 1'b0);
          FN_SUB:  alucontrol = ac_pack(1'b1, 1'b0, AC_UNIT_ARITH, 1'b0, 1'b0);
          FN_SUBU: alucontrol = ac_pack(1'b1, 1'b1, AC_UNIT_ARITH, 1'b0, 1'b0);
          FN_AND:  alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_LOGIC, 1'b0, 1'b0);
          FN_OR:   alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_LOGIC, 1'b0, 1'b1);
          FN_XOR:  alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_LOGIC, 1'b1, 1'b0);
          FN_NOR:  alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_LOGIC, 1'b1, 1'b1);
          FN_SLT:  alucontrol = ac_pack(1'b1, 1'b0, AC_UNIT_SLT, 1'b0, 1'b0);
          FN_SLTU: alucontrol = ac_pack(1'b1, 1'b1, AC_UNIT_SLT, 1'b0, 1'b0);
          // constant and variable shifts differ only in the A-input select
          FN_SLL, FN_SLLV: alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_SHIFT, 1'b0, 1'b0);
          FN_SRL, FN_SRLV: alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_SHIFT, 1'b0, 1'b1);
          FN_SRA, FN_SRAV: alucontrol = ac_pack(1'b0, 1'b0, AC_UNIT_SHIFT, 1'b1, 1'b1);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM over a shared ALU and unified memory.
// Define MULTICYCLE_PERF_CNT_EN to enable the cycle/instruction counters.
//
// state   | meaning
// FETCH   | read instr at pc, pc+4 on mem_ready
// DECODE  | branch target into ALUOut, dispatch on opcode
// MEMADR  | base + signimm for lw/sw
// MEMRD   | data read, wait for mem_ready
// MEMWB   | memory data to rt
// MEMWR   | store strobe held until mem_ready
// RTYPE   | A op B (or shamt) per funct
// ALUWB   | ALU result to rd
// IMMEX   | A + / slt signimm
// IMMWB   | ALU result to rt
// BRANCH  | compare, pc <= ALUOut if taken
// JUMP    | pc <= jump target
// JAL     | pc <= jump target, r31 <= pc
// JR      | pc <= rs
// ILLEGAL | unknown opcode/funct, flag sticky
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT      = 1'b1,
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        pc_en,
  output logic [1:0]  pcsrc,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic        chooseShift,
  output logic        regwrite,
  output logic [1:0]  regdst,
  output logic        memtoreg,
  output logic        jal,
  output logic [5:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state_o,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  if (RESET_STATE_FETCH != 1'b1) begin : g_bad_reset_state
    $error("multicycle_ctrl: RESET_STATE_FETCH must be 1");
  end

  state_e state_q, state_n;
  logic   illegal_q;
  aluop_e aluop;

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:     state_n = S_MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR)          state_n = S_JR;
            else if (funct_is_alu(funct)) state_n = S_RTYPE;
            else                          state_n = S_ILLEGAL;
          end
          OP_BEQ, OP_BNE:   state_n = S_BRANCH;
          OP_ADDI, OP_SLTI: state_n = S_IMMEX;
          OP_J:             state_n = S_JUMP;
          OP_JAL:           state_n = S_JAL;
          default:          state_n = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_RTYPE:  state_n = S_ALUWB;
      S_IMMEX:  state_n = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_JR:
                state_n = S_FETCH;
      S_ILLEGAL: if (!ILLEGAL_HALT) state_n = S_FETCH;
      default:  state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_n == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // Outputs are gated by reset so an in-flight access is dropped at once.
  always_comb begin
    mem_req     = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pc_en       = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    chooseShift = 1'b0;
    regwrite    = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 1'b0;
    jal         = 1'b0;
    aluop       = ALUOP_ADD;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pc_en   = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPE: begin
          alusrca     = 1'b1;
          aluop       = ALUOP_FUNCT;
          chooseShift = funct_is_shamt(funct);
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 2'b01;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        end
        S_IMMWB: regwrite = 1'b1;
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          pc_en   = (opcode == OP_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          pcsrc = 2'b10;
          pc_en = 1'b1;
        end
        S_JAL: begin
          pcsrc    = 2'b10;
          pc_en    = 1'b1;
          regwrite = 1'b1;
          regdst   = 2'b10;
          jal      = 1'b1;
        end
        S_JR: begin
          pcsrc = 2'b11;
          pc_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign illegal = illegal_q;
  assign state_o = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_q, instr_q;

  // DECODE never returns to FETCH, so any entry into FETCH retires one instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (state_n == S_FETCH && state_q != S_FETCH) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each instruction's expected per-cycle
// state and control vector is queued, and a negedge monitor compares them.
module tb_multicycle_ctrl;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                         ST_RTYPE = 4'd6, ST_ALUWB = 4'd7, ST_IMMEX = 4'd8,
                         ST_IMMWB = 4'd9, ST_BRANCH = 4'd10, ST_JUMP = 4'd11,
                         ST_JAL = 4'd12, ST_JR = 4'd13, ST_ILLEGAL = 4'd14;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         SLTI = 6'b001010, J = 6'b000010, JAL = 6'b000011;

  typedef struct packed {
    logic       mem_req, iord, memwrite, irwrite, pc_en;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       chooseshift, regwrite;
    logic [1:0] regdst;
    logic       memtoreg, jal;
    logic [5:0] aluc;
    logic       illegal;
  } outs_t;

  typedef struct { logic [3:0] st; outs_t o; string tag; } exp_t;
  typedef struct { logic rdy; logic z; } drv_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, iord, memwrite, irwrite, pc_en, alusrca, chooseShift;
  logic regwrite, memtoreg, jal, illegal;
  logic [1:0] pcsrc, alusrcb, regdst;
  logic [5:0] alucontrol;
  logic [3:0] state_o;
  logic [31:0] cycle_count, instr_count;

  exp_t exp_q[$];
  drv_t drv_q[$];
  int   checks = 0, failures = 0;
  bit   ill_model = 1'b0;

  logic [5:0] op_tab[11] = '{LW, SW, RT, RT, RT, BEQ, BNE, ADDI, SLTI, J, JAL};
  logic [5:0] fn_tab[17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04,
                             6'h06, 6'h07, 6'h08};

  always #5 clk = ~clk;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1), .RESET_STATE_FETCH(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .pc_en(pc_en), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .chooseShift(chooseShift), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .jal(jal), .alucontrol(alucontrol),
    .illegal(illegal), .state_o(state_o), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  function automatic outs_t dut_outs();
    outs_t o;
    o.mem_req = mem_req; o.iord = iord; o.memwrite = memwrite;
    o.irwrite = irwrite; o.pc_en = pc_en; o.pcsrc = pcsrc;
    o.alusrca = alusrca; o.alusrcb = alusrcb; o.chooseshift = chooseShift;
    o.regwrite = regwrite; o.regdst = regdst; o.memtoreg = memtoreg;
    o.jal = jal; o.aluc = alucontrol; o.illegal = illegal;
    return o;
  endfunction

  // ALU encoding {negate_b, unsigned, unit, op}: unit 00 add,01 logic,10 shift,11 slt
  function automatic logic [5:0] ref_aluc(input logic [5:0] fn);
    case (fn)
      6'h20: return 6'b000000;  6'h21: return 6'b010000;
      6'h22: return 6'b100000;  6'h23: return 6'b110000;
      6'h24: return 6'b000100;  6'h25: return 6'b000101;
      6'h26: return 6'b000110;  6'h27: return 6'b000111;
      6'h2a: return 6'b101100;  6'h2b: return 6'b111100;
      6'h00, 6'h04: return 6'b001000;
      6'h02, 6'h06: return 6'b001001;
      6'h03, 6'h07: return 6'b001011;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic bit known_funct(input logic [5:0] fn);
    return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                      6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  task automatic push(input logic [3:0] st, input outs_t o, input logic rdy,
                      input logic z, input string tag);
    exp_t e;
    drv_t d;
    e.st = st; e.o = o; e.o.illegal = ill_model; e.tag = tag;
    d.rdy = rdy; d.z = z;
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  // Reference model: expected cycle sequence of one instruction.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm, input bit abort_mem);
    outs_t o;
    string t;
    t = $sformatf("op%b_fn%b", op, fn);
    opcode = op;
    funct  = fn;
    for (int i = 0; i <= wf; i++) begin
      o = '0; o.mem_req = 1'b1; o.alusrcb = 2'b01;
      o.irwrite = (i == wf); o.pc_en = (i == wf);
      push(ST_FETCH, o, (i == wf), rbit(), {t, "_fetch"});
    end
    o = '0; o.alusrcb = 2'b11;
    push(ST_DECODE, o, rbit(), rbit(), {t, "_decode"});
    if (op == LW || op == SW) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
      push(ST_MEMADR, o, rbit(), rbit(), {t, "_memadr"});
      for (int i = 0; i <= wm; i++) begin
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.memwrite = (op == SW);
        push(op == SW ? ST_MEMWR : ST_MEMRD, o, (i == wm) && !abort_mem, rbit(),
             {t, "_mem"});
      end
      if (op == LW) begin
        o = '0; o.regwrite = 1'b1; o.memtoreg = 1'b1;
        push(ST_MEMWB, o, rbit(), rbit(), {t, "_memwb"});
      end
    end else if (op == RT && fn == 6'b001000) begin
      o = '0; o.pcsrc = 2'b11; o.pc_en = 1'b1;
      push(ST_JR, o, rbit(), rbit(), {t, "_jr"});
    end else if (op == RT && known_funct(fn)) begin
      o = '0; o.alusrca = 1'b1; o.aluc = ref_aluc(fn);
      o.chooseshift = fn inside {6'h00, 6'h02, 6'h03};
      push(ST_RTYPE, o, rbit(), rbit(), {t, "_rtype"});
      o = '0; o.regwrite = 1'b1; o.regdst = 2'b01;
      push(ST_ALUWB, o, rbit(), rbit(), {t, "_aluwb"});
    end else if (op == ADDI || op == SLTI) begin
      o = '0; o.alusrca = 1'b1; o.alusrcb = 2'b10;
      o.aluc = (op == SLTI) ? 6'b101100 : 6'b000000;
      push(ST_IMMEX, o, rbit(), rbit(), {t, "_immex"});
      o = '0; o.regwrite = 1'b1;
      push(ST_IMMWB, o, rbit(), rbit(), {t, "_immwb"});
    end else if (op == BEQ || op == BNE) begin
      o = '0; o.alusrca = 1'b1; o.aluc = 6'b100000; o.pcsrc = 2'b01;
      o.pc_en = (op == BEQ) ? z : !z;
      push(ST_BRANCH, o, rbit(), z, {t, "_branch"});
    end else if (op == J || op == JAL) begin
      o = '0; o.pcsrc = 2'b10; o.pc_en = 1'b1;
      if (op == JAL) begin
        o.regwrite = 1'b1; o.regdst = 2'b10; o.jal = 1'b1;
      end
      push(op == JAL ? ST_JAL : ST_JUMP, o, rbit(), rbit(), {t, "_jump"});
    end else begin
      ill_model = 1'b1;
      for (int i = 0; i < 12; i++) begin
        o = '0;
        push(ST_ILLEGAL, o, rbit(), rbit(), {t, "_illegal"});
      end
    end
  endtask

  task automatic run_drv();
    drv_t d;
    while (drv_q.size() > 0) begin
      d = drv_q.pop_front();
      mem_ready = d.rdy;
      zero = d.z;
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_state"}, 32'(state_o), 32'(e.st));
      chk({e.tag, "_outs"}, 32'(dut_outs()), 32'(e.o));
      checks++;
      if ((32'(regwrite) + 32'(memwrite) + 32'(irwrite)) > 32'd1) begin
        failures++;
        $display("FAIL %s_strobe_overlap: got rw=%0b mw=%0b iw=%0b required at most one",
                 e.tag, regwrite, memwrite, irwrite);
      end
    end
  end

  task automatic chk_reset_outs(input string name);
    chk({name, "_state"}, 32'(state_o), 32'(ST_FETCH));
    chk({name, "_outs"}, 32'(dut_outs()), 32'd0);
  endtask

  initial begin
    logic [5:0] op, fn;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset_initial");
    chk("reset_cycle_count", cycle_count, 32'd0);
    chk("reset_instr_count", instr_count, 32'd0);
    reset = 1'b0;

    issue(LW, 6'h00, 1'b0, 0, 0, 1'b0);           run_drv();
    issue(SW, 6'h00, 1'b0, 0, 3, 1'b0);           run_drv();
    issue(BEQ, 6'h00, 1'b1, 0, 0, 1'b0);          run_drv();
    issue(BEQ, 6'h00, 1'b0, 0, 0, 1'b0);          run_drv();
    issue(BNE, 6'h00, 1'b0, 1, 0, 1'b0);          run_drv();
    issue(JAL, 6'h00, 1'b0, 0, 0, 1'b0);          run_drv();
    issue(RT, 6'b000000, 1'b0, 0, 0, 1'b0);       run_drv();
    issue(RT, 6'b001000, 1'b0, 0, 0, 1'b0);       run_drv();
    issue(LW, 6'h00, 1'b0, 2, 3, 1'b0);           run_drv();

    for (int n = 0; n < 40; n++) begin
      op = op_tab[$urandom_range(0, 10)];
      fn = fn_tab[$urandom_range(0, 16)];
      issue(op, fn, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      run_drv();
    end

    // store abandoned by reset while memory is still busy
    issue(SW, 6'h00, 1'b0, 1, 2, 1'b1);
    run_drv();
    mem_ready = 1'b0;
    #1;
    chk("abort_pre_state", 32'(state_o), 32'(ST_MEMWR));
    chk("abort_pre_memwrite", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outs("abort_reset");
    chk("abort_cycle_count", cycle_count, 32'd0);
    chk("abort_instr_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_hold_memwrite", 32'(memwrite), 32'd0);
    reset = 1'b0;
    ill_model = 1'b0;

    issue(RT, 6'h20, 1'b0, 0, 0, 1'b0);           run_drv();
    issue(RT, 6'h22, 1'b0, 0, 0, 1'b0);           run_drv();
`ifdef MULTICYCLE_PERF_CNT_EN
    chk("perf_instr_count", instr_count, 32'd2);
    chk("perf_cycle_count", cycle_count, 32'd8);
`else
    chk("perf_instr_count_tied", instr_count, 32'd0);
    chk("perf_cycle_count_tied", cycle_count, 32'd0);
`endif

    issue(6'b111111, 6'h00, 1'b0, 0, 0, 1'b0);    run_drv();
    reset = 1'b1;
    #1;
    chk_reset_outs("illegal_op_reset");
    chk("illegal_op_flag_cleared", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ill_model = 1'b0;

    issue(RT, 6'b111111, 1'b0, 1, 0, 1'b0);       run_drv();
    reset = 1'b1;
    #1;
    chk_reset_outs("illegal_fn_reset");
    chk("illegal_fn_flag_cleared", 32'(illegal), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
